// File: rtl/pipe_pkg.sv
// Shared types and defaults for the inter-stage pipeline registers.
package pipe_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    CMD_LOAD,
    CMD_HOLD,
    CMD_FLUSH
  } stage_cmd_e;

  // A flush wins over a stall so that a squashed instruction cannot linger.
  function automatic stage_cmd_e stage_cmd(input logic flush, input logic stall);
    if (flush)      return CMD_FLUSH;
    else if (stall) return CMD_HOLD;
    else            return CMD_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (inc_i && ~&cnt_q)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with stall/flush and control squashing.
// Define PIPE_STAGE_PERF_CNT_EN to build the stall/bubble performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = CTRL_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              cnt_clr_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  stage_cmd_e cmd;
  assign cmd = stage_cmd(flush_i, stall_i);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Data is left untouched on a flush: it is dead once valid drops.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    case (cmd)
      CMD_FLUSH: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_BUBBLE;
      end
      CMD_LOAD: begin
        valid_d = valid_i;
        data_d  = data_i;
        ctrl_d  = valid_i ? ctrl_i : CTRL_BUBBLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic stall_inc, bubble_inc;
  assign stall_inc  = (cmd == CMD_HOLD);
  assign bubble_inc = (cmd == CMD_FLUSH) || ((cmd == CMD_LOAD) && !valid_i);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr_i),
    .inc_i (bubble_inc),
    .cnt_o (bubble_cnt_o)
  );
`else
  logic perf_unused;
  assign perf_unused  = cnt_clr_i;
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

  // A bubble must never carry live control bits.
  a_bubble_squashed: assert property (@(posedge clk) disable iff (reset)
    !valid_q |-> (ctrl_q == CTRL_BUBBLE));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (CNT_W=4 so saturation is reachable).
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0, cnt_clr_i = 1'b0;
  logic [15:0] ctrl_i = '0;
  logic [63:0] data_i = '0;
  logic        valid_o;
  logic [15:0] ctrl_o;
  logic [63:0] data_o;
  logic [3:0]  stall_cnt_o, bubble_cnt_o;

  int checks = 0;
  int failures = 0;

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(64), .CTRL_BUBBLE(16'h0000), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ctrl_i       (ctrl_i),
    .data_i       (data_i),
    .cnt_clr_i    (cnt_clr_i),
    .valid_o      (valid_o),
    .ctrl_o       (ctrl_o),
    .data_o       (data_o),
    .stall_cnt_o  (stall_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ec(input int n);
    return PERF ? 4'(n) : 4'd0;
  endfunction

  // Drive one command, let one rising edge pass, return at the falling edge.
  task automatic cyc(input logic fl, input logic st, input logic vl,
                     input logic [15:0] c, input logic [63:0] d, input logic clr);
    flush_i = fl; stall_i = st; valid_i = vl; ctrl_i = c; data_i = d; cnt_clr_i = clr;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (!valid_o && ctrl_o !== 16'h0000) begin
      failures++;
      $display("FAIL squash_invariant: ctrl_o=%h with valid_o=0, required 0000", ctrl_o);
    end
  endtask

  task automatic chk_dp(input string nm, input logic v, input logic [15:0] c, input logic [63:0] d);
    checks++;
    if (valid_o !== v || ctrl_o !== c || data_o !== d) begin
      failures++;
      $display("FAIL %s: got v=%b c=%h d=%h, required v=%b c=%h d=%h",
               nm, valid_o, ctrl_o, data_o, v, c, d);
    end
  endtask

  task automatic chk_cnt(input string nm, input int s, input int b);
    checks++;
    if (stall_cnt_o !== ec(s) || bubble_cnt_o !== ec(b)) begin
      failures++;
      $display("FAIL %s: got stall=%0d bubble=%0d, required stall=%0d bubble=%0d",
               nm, stall_cnt_o, bubble_cnt_o, ec(s), ec(b));
    end
  endtask

  task automatic test_reset;
    valid_i = 1'b1; ctrl_i = 16'hFFFF; data_i = 64'hDEAD; flush_i = 1'b0; stall_i = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_dp("reset_async_dp", 1'b0, 16'h0000, 64'h0);
    chk_cnt("reset_async_cnt", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    chk_dp("reset_held_dp", 1'b0, 16'h0000, 64'h0);
  endtask

  task automatic test_load;
    cyc(0, 0, 1, 16'hA5A5, 64'h1234, 0);
    chk_dp("load_a5a5", 1'b1, 16'hA5A5, 64'h1234);
    chk_cnt("load_cnt", 0, 0);
    cyc(0, 0, 0, 16'hFFFF, 64'h5678, 0);
    chk_dp("invalid_squash", 1'b0, 16'h0000, 64'h5678);
    chk_cnt("invalid_bubble_cnt", 0, 1);
  endtask

  task automatic test_back_to_back;
    cyc(0, 0, 1, 16'h1111, 64'hABCD, 0);
    chk_dp("b2b_first", 1'b1, 16'h1111, 64'hABCD);
    cyc(0, 0, 1, 16'h2222, 64'hBEEF, 0);
    chk_dp("b2b_second", 1'b1, 16'h2222, 64'hBEEF);
  endtask

  task automatic test_stall_flush;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, i[0], 16'h3000 + 16'(i), 64'h9000 + 64'(i), 0);
      chk_dp("stall_frozen", 1'b1, 16'h2222, 64'hBEEF);
    end
    chk_cnt("stall_cnt3", 3, 1);
    cyc(1, 1, 1, 16'h7777, 64'h9999, 0);
    chk_dp("flush_over_stall", 1'b0, 16'h0000, 64'hBEEF);
    chk_cnt("flush_cnt", 3, 2);
    cyc(0, 1, 1, 16'h8888, 64'h1, 0);
    chk_dp("hold_bubble", 1'b0, 16'h0000, 64'hBEEF);
    chk_cnt("hold_bubble_cnt", 4, 2);
    cyc(0, 0, 1, 16'h3333, 64'h4444, 1);
    chk_dp("clr_keeps_datapath", 1'b1, 16'h3333, 64'h4444);
    chk_cnt("clr_load", 0, 0);
    cyc(1, 0, 1, 16'h5555, 64'h6666, 1);
    chk_dp("clr_flush_dp", 1'b0, 16'h0000, 64'h4444);
    chk_cnt("clr_beats_flush_inc", 0, 0);
  endtask

  task automatic test_saturation;
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 1, 1, 16'h0101, 64'h0202, 0);
      if (i == 14) chk_cnt("stall_cnt14", 14, 0);
      if (i == 15) chk_cnt("stall_cnt15", 15, 0);
    end
    chk_cnt("stall_sat20", 15, 0);
    cyc(0, 1, 1, 16'h0101, 64'h0202, 1);
    chk_cnt("clr_beats_stall_inc", 0, 0);
    cyc(0, 1, 1, 16'h0101, 64'h0202, 0);
    chk_cnt("stall_after_clr", 1, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 16'hFFFF, 64'(i), 0);
    chk_cnt("bubble_sat", 1, 15);
    chk_dp("bubble_sat_dp", 1'b0, 16'h0000, 64'd16);
    cyc(0, 0, 1, 16'h0F0F, 64'h0E0E, 1);
    chk_cnt("clr_all", 0, 0);
  endtask

  task automatic test_reset_mid_stall;
    cyc(0, 0, 1, 16'h5A5A, 64'h77, 0);
    chk_dp("pre_reset_load", 1'b1, 16'h5A5A, 64'h77);
    cyc(0, 1, 0, 16'h0001, 64'h88, 0);
    chk_cnt("pre_reset_stall", 1, 0);
    #2 reset = 1'b1;
    #1;
    chk_dp("reset_mid_stall_dp", 1'b0, 16'h0000, 64'h0);
    chk_cnt("reset_mid_stall_cnt", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 1, 1, 16'h1234, 64'h55, 0);
    chk_dp("post_reset_hold", 1'b0, 16'h0000, 64'h0);
    chk_cnt("post_reset_hold_cnt", 1, 0);
    cyc(0, 0, 1, 16'hC3C3, 64'hF00D, 0);
    chk_dp("post_reset_load", 1'b1, 16'hC3C3, 64'hF00D);
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_stall_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the pipelined ARM core. It replaces the fixed-width, reset-only stage registers with one block that any stage boundary (F/D, D/E, E/M, M/W) can use.
- Carries a control field and a data payload, each of configurable width.
- Supports hazard-unit stall (hold) and flush (bubble insertion), and tracks a valid bit.
- Squashes the control bits of invalid instructions so a bubble can never write a register, memory or the flags.
- Optionally provides saturating stall and bubble performance counters.

Parameters:
- CTRL_W, 16, width of the control field (RegWrite, MemWrite, FlagWrite, ALUControl, Cond, ...); this is the field cleared on flush.
- DATA_W, 64, width of the payload (register numbers, operands, immediate/extend, shift amount).
- CTRL_BUBBLE, '0, CTRL_W-bit value loaded into ctrl_o for a bubble.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall_i  in  1  hazard unit: hold the current contents.
- flush_i  in  1  hazard unit / branch: insert a bubble.
- valid_i  in  1  upstream instruction is valid.
- ctrl_i  in  CTRL_W  upstream control bits.
- data_i  in  DATA_W  upstream payload.
- cnt_clr_i  in  1  synchronous clear of both counters.
- valid_o  out  1  registered valid.
- ctrl_o  out  CTRL_W  registered control bits; equal to CTRL_BUBBLE whenever valid_o=0.
- data_o  out  DATA_W  registered payload.
- stall_cnt_o  out  CNT_W  cycles spent stalled (saturating).
- bubble_cnt_o  out  CNT_W  bubbles emitted (saturating).

Behaviour:
- Reset values (asynchronous): valid_o=0, ctrl_o=CTRL_BUBBLE, data_o=0, stall_cnt_o=0, bubble_cnt_o=0.
- Latency is 1 cycle from input to output on a load.
- Each clock edge, exactly one command applies, in priority order: reset > FLUSH (flush_i=1) > HOLD (stall_i=1) > LOAD.
- FLUSH:
  - valid_o<=0, ctrl_o<=CTRL_BUBBLE.
  - data_o holds its previous value; it is don't-care but deterministic.
  - flush_i together with stall_i is a FLUSH, not a HOLD.
- HOLD: all outputs hold their values. Holding a bubble keeps it a bubble.
- LOAD:
  - valid_o<=valid_i and data_o<=data_i.
  - ctrl_o<=ctrl_i if valid_i=1, else CTRL_BUBBLE.
- Invariant, checked every cycle after reset: valid_o=0 implies ctrl_o==CTRL_BUBBLE.
- stall_cnt_o increments on each HOLD cycle.
- bubble_cnt_o increments on:
  - each FLUSH cycle;
  - each LOAD cycle with valid_i=0.
- Counter rules:
  - Both counters saturate at 2^CNT_W-1; there is no wrap-around.
  - cnt_clr_i has priority over increment; a clear together with an increment gives 0.
  - cnt_clr_i does not affect the datapath.
- Reset asserted mid-stall or mid-flush clears everything immediately; after reset deasserts, the first edge evaluates the commands normally.
- Only whole-register enables are used; no gated clocks.

Optional Feature:
PIPE_STAGE_PERF_CNT_EN
- Defined: both counters and cnt_clr_i are implemented as described above.
- Undefined:
  - No counter flops are synthesised.
  - stall_cnt_o and bubble_cnt_o are tied to 0.
  - cnt_clr_i is ignored.
  - Port list is unchanged, so instantiations are identical either way.

Decomposition:
- Package pipe_pkg contains:
  - enum stage_cmd_e {CMD_LOAD, CMD_HOLD, CMD_FLUSH};
  - function stage_cmd(flush, stall) returning stage_cmd_e;
  - localparam defaults for CTRL_W, DATA_W and CNT_W.
- Sub-module sat_counter (params W; ports clk, reset, clr_i, inc_i, cnt_o) is instantiated twice, inside the PIPE_STAGE_PERF_CNT_EN guard.
- The main module contains the command decode, the valid/ctrl/data registers, and the squash mux.

Test Plan:
- Reset with arbitrary inputs -> valid_o=0, ctrl_o=CTRL_BUBBLE, data_o=0, both counters 0, with no clock edge required.
- LOAD stream: valid_i=1, ctrl_i=16'hA5A5, data_i=64'h1234 -> one cycle later valid_o=1, ctrl_o=16'hA5A5, data_o=64'h1234.
- valid_i=0, ctrl_i=16'hFFFF -> ctrl_o=16'h0000, valid_o=0, bubble_cnt_o increments by 1.
- stall_i=1 for 3 cycles while inputs change -> outputs frozen, stall_cnt_o=3. Then flush_i=1 together with stall_i=1 -> valid_o=0, ctrl_o=0, data_o unchanged, bubble_cnt_o=1, stall_cnt_o stays 3.
- CNT_W=4 with stall_i held for 20 cycles -> stall_cnt_o saturates at 15. cnt_clr_i=1 together with stall_i=1 -> stall_cnt_o=0.
- Assert reset mid-stall while valid_o=1 -> immediate clear. Rerun all scenarios with the macro undefined -> counters read 0 and datapath results are identical.
